requant_gain_ctrl: RTL and testbench

- Configuration and sequencing controller for the requantizer.
- Holds a double-buffered per-channel gain table: the host fills the shadow bank, and the banks swap only at a frame boundary, so no spectrum is ever requantized with mixed gains.
- Issues the requantizer arm pulse and tracks its running state from its sync output.
- Accumulates per-frame overflow statistics for host readback.

---
 rtl/requant_ctrl_pkg.sv | 14 +
 rtl/gain_bank_ram.sv | 25 ++
 rtl/requant_gain_ctrl.sv | 166 ++++++++++++++++
 tb/tb_requant_gain_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_ctrl_pkg.sv
// Shared types and default dimensions for the requantizer gain controller.
// The commit FSM enum is used by requant_gain_ctrl.
package requant_ctrl_pkg;
   localparam int N_CHAN_DEF = 2048;
   localparam int ADDR_W_DEF = 11;
   localparam int GAIN_W_DEF = 11;
   localparam int CNT_W_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_SWAP    = 2'd2
   } commit_state_e;
endpackage

// File: rtl/gain_bank_ram.sv
// Dual-bank gain table: one synchronous write port, one asynchronous read port.
// The bank select is the top address bit, so both banks share one array.
module gain_bank_ram #(
   parameter int ADDR_W = 11,
   parameter int GAIN_W = 11
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [GAIN_W-1:0] wr_data,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [GAIN_W-1:0] rd_data
);
   logic [GAIN_W-1:0] mem [2**(ADDR_W+1)];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   assign rd_data = mem[{rd_bank, rd_addr}];
endmodule

// File: rtl/requant_gain_ctrl.sv
// Requantizer configuration/sequencing: frame-aligned gain bank swap, arm pulse,
// running tracking and per-frame overflow statistics.
module requant_gain_ctrl
   import requant_ctrl_pkg::*;
#(
   parameter int N_CHAN = N_CHAN_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int GAIN_W = GAIN_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              host_wr_en,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [GAIN_W-1:0] host_wr_data,
   input  logic              host_commit,
   input  logic              host_arm,
   input  logic [ADDR_W-1:0] rq_addr,
   input  logic              rq_sync,
   input  logic              rq_overflow,
   output logic [GAIN_W-1:0] gain,
   output logic              rq_arm,
   output logic              busy,
   output logic              active_bank,
   output logic              table_valid,
   output logic              running,
   output logic              wr_drop,
   output logic              arm_err,
   output logic [ADDR_W:0]   ovf_last,
   output logic [CNT_W-1:0]  frame_cnt
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CHAN - 1);
   localparam logic [ADDR_W:0]   ACC_MAX   = (ADDR_W + 1)'(N_CHAN);

   commit_state_e    state_q, state_d;
   logic             active_bank_q, active_bank_d;
   logic             table_valid_q, table_valid_d;
   logic             running_q, running_d;
   logic             rq_arm_q, rq_arm_d;
   logic             wr_drop_q, wr_drop_d;
   logic             arm_err_q, arm_err_d;
   logic             eof_dly_q, eof_dly_d;
   logic [ADDR_W:0]  acc_q, acc_d;
   logic [ADDR_W:0]  ovf_last_q, ovf_last_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   logic             eof;
   logic             ovf_hit;
   logic             wr_accept;
   logic [ADDR_W:0]  ovf_sum;

   gain_bank_ram #(
      .ADDR_W (ADDR_W),
      .GAIN_W (GAIN_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_accept),
      .wr_bank (~active_bank_q),
      .wr_addr (host_wr_addr),
      .wr_data (host_wr_data),
      .rd_bank (active_bank_q),
      .rd_addr (rq_addr),
      .rd_data (gain)
   );

   always_comb begin
      eof       = ce && running_q && (rq_addr == LAST_ADDR);
      ovf_hit   = ce && running_q && rq_overflow;
      wr_accept = host_wr_en && (state_q == ST_IDLE);
      ovf_sum   = acc_q + {{ADDR_W{1'b0}}, ovf_hit};

      state_d       = state_q;
      active_bank_d = active_bank_q;
      table_valid_d = table_valid_q;
      wr_drop_d     = wr_drop_q;
      arm_err_d     = arm_err_q;
      eof_dly_d     = eof_dly_q;
      acc_d         = acc_q;
      ovf_last_d    = ovf_last_q;
      frame_cnt_d   = frame_cnt_q;
      running_d     = running_q | (ce & rq_sync);
      rq_arm_d      = host_arm && table_valid_q;

      // The bank flips on entry to SWAP so channel 0 of the next frame reads it.
      case (state_q)
         ST_IDLE: begin
            if (host_commit) begin
               state_d   = ST_PENDING;
               wr_drop_d = 1'b0;
            end
         end
         ST_PENDING: begin
            if (ce && (!running_q || eof)) begin
               state_d       = ST_SWAP;
               active_bank_d = ~active_bank_q;
               table_valid_d = 1'b1;
            end
         end
         ST_SWAP: begin
            if (ce) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (host_wr_en && (state_q != ST_IDLE)) begin
         wr_drop_d = 1'b1;
      end

      if (host_arm) begin
         arm_err_d = ~table_valid_q;
      end

      // Overflow is registered by the requantizer, so the frame closes one ce-cycle after eof.
      if (ce) begin
         eof_dly_d = eof;
         if (eof_dly_q) begin
            ovf_last_d  = (ovf_sum > ACC_MAX) ? ACC_MAX : ovf_sum;
            acc_d       = '0;
            frame_cnt_d = frame_cnt_q + 1'b1;
         end else if (ovf_hit && (acc_q != ACC_MAX)) begin
            acc_d = acc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         active_bank_q <= 1'b0;
         table_valid_q <= 1'b0;
         running_q     <= 1'b0;
         rq_arm_q      <= 1'b0;
         wr_drop_q     <= 1'b0;
         arm_err_q     <= 1'b0;
         eof_dly_q     <= 1'b0;
         acc_q         <= '0;
         ovf_last_q    <= '0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         active_bank_q <= active_bank_d;
         table_valid_q <= table_valid_d;
         running_q     <= running_d;
         rq_arm_q      <= rq_arm_d;
         wr_drop_q     <= wr_drop_d;
         arm_err_q     <= arm_err_d;
         eof_dly_q     <= eof_dly_d;
         acc_q         <= acc_d;
         ovf_last_q    <= ovf_last_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign active_bank = active_bank_q;
   assign table_valid = table_valid_q;
   assign running     = running_q;
   assign rq_arm      = rq_arm_q;
   assign wr_drop     = wr_drop_q;
   assign arm_err     = arm_err_q;
   assign ovf_last    = ovf_last_q;
   assign frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_requant_gain_ctrl.sv
// Self-checking bench for requant_gain_ctrl: bank swap sequencing, arm handling,
// dropped writes, per-frame overflow statistics and asynchronous reset.
module tb_requant_gain_ctrl;
   localparam int N = 2048;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic        host_wr_en = 1'b0;
   logic [10:0] host_wr_addr = '0;
   logic [10:0] host_wr_data = '0;
   logic        host_commit = 1'b0;
   logic        host_arm = 1'b0;
   logic [10:0] rq_addr = '0;
   logic        rq_sync = 1'b0;
   logic        rq_overflow = 1'b0;
   logic [10:0] gain;
   logic        rq_arm, busy, active_bank, table_valid, running, wr_drop, arm_err;
   logic [11:0] ovf_last;
   logic [31:0] frame_cnt;

   int tests = 0;
   int fails = 0;
   int sb[$];
   int exp_frames = 0;
   bit ovf_pend = 1'b0;

   requant_gain_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .host_wr_en   (host_wr_en),
      .host_wr_addr (host_wr_addr),
      .host_wr_data (host_wr_data),
      .host_commit  (host_commit),
      .host_arm     (host_arm),
      .rq_addr      (rq_addr),
      .rq_sync      (rq_sync),
      .rq_overflow  (rq_overflow),
      .gain         (gain),
      .rq_arm       (rq_arm),
      .busy         (busy),
      .active_bank  (active_bank),
      .table_valid  (table_valid),
      .running      (running),
      .wr_drop      (wr_drop),
      .arm_err      (arm_err),
      .ovf_last     (ovf_last),
      .frame_cnt    (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic fill_shadow(input logic [10:0] value, input bit commit_last);
      for (int a = 0; a < N; a++) begin
         host_wr_en   = 1'b1;
         host_wr_addr = 11'(a);
         host_wr_data = value;
         host_commit  = commit_last && (a == N - 1);
         tick();
      end
      host_wr_en  = 1'b0;
      host_commit = 1'b0;
   endtask

   // One frame of requantizer traffic; overflow for channel a is driven the cycle after a.
   // mode 0: no overflow, 1: channels 10/500/2047, 2: every channel.
   task automatic run_frame(input int mode, input int commit_at, input int wr_at,
                            input logic [10:0] exp_gain, input int len);
      int cnt = 0;
      int exp_ovf;
      bit flag;
      for (int a = 0; a < len; a++) begin
         ce          = 1'b1;
         rq_addr     = 11'(a);
         rq_overflow = ovf_pend;
         flag        = (mode == 2) || (mode == 1 && (a == 10 || a == 500 || a == N - 1));
         ovf_pend    = flag;
         if (flag) cnt++;
         host_commit  = (a == commit_at);
         host_wr_en   = (a == wr_at);
         host_wr_addr = 11'd7;
         host_wr_data = 11'd3;
         #1;
         tests++;
         if (gain !== exp_gain) begin
            fails++;
            $display("FAIL gain addr=%0d got=%0d exp=%0d", a, gain, exp_gain);
         end
         tick();
         host_commit = 1'b0;
         host_wr_en  = 1'b0;
         if (a == 0) begin
            if (sb.size() > 0) begin
               exp_ovf = sb.pop_front();
               exp_frames++;
               tests++;
               if (ovf_last !== 12'(exp_ovf)) begin
                  fails++;
                  $display("FAIL ovf_last frame=%0d got=%0d exp=%0d", exp_frames, ovf_last, exp_ovf);
               end
            end
            tests++;
            if (frame_cnt !== 32'(exp_frames)) begin
               fails++;
               $display("FAIL frame_cnt got=%0d exp=%0d", frame_cnt, exp_frames);
            end
         end
      end
      if (len == N) sb.push_back(cnt);
      $display("[TB] frame done mode=%0d len=%0d ovf_expected=%0d", mode, len, cnt);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      ce  = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tests++;
      if ({busy, active_bank, table_valid, running, rq_arm, wr_drop, arm_err} !== 7'b0) begin
         fails++;
         $display("FAIL reset_flags got=%b exp=0000000",
                  {busy, active_bank, table_valid, running, rq_arm, wr_drop, arm_err});
      end
      tests++;
      if (ovf_last !== 12'd0 || frame_cnt !== 32'd0) begin
         fails++;
         $display("FAIL reset_stats got ovf_last=%0d frame_cnt=%0d exp 0/0", ovf_last, frame_cnt);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_arm_before_table;
      host_arm = 1'b1;
      tick();
      host_arm = 1'b0;
      tests++;
      if (rq_arm !== 1'b0 || arm_err !== 1'b1) begin
         fails++;
         $display("FAIL arm_no_table got rq_arm=%b arm_err=%b exp 0/1", rq_arm, arm_err);
      end
      tick();
      tests++;
      if (rq_arm !== 1'b0) begin
         fails++;
         $display("FAIL arm_no_table_late got rq_arm=%b exp 0", rq_arm);
      end
      $display("[TB] test_arm_before_table done");
   endtask

   task automatic test_idle_commit;
      int probe[4];
      probe = '{0, 1234, N - 1, int'($urandom_range(1, N - 2))};
      fill_shadow(11'd5, 1'b1);
      tests++;
      if (busy !== 1'b1 || active_bank !== 1'b0) begin
         fails++;
         $display("FAIL commit_pending got busy=%b bank=%b exp 1/0", busy, active_bank);
      end
      tick();
      tests++;
      if (busy !== 1'b1 || active_bank !== 1'b1 || table_valid !== 1'b1) begin
         fails++;
         $display("FAIL commit_swap got busy=%b bank=%b valid=%b exp 1/1/1", busy, active_bank, table_valid);
      end
      tick();
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL commit_done got busy=%b exp 0", busy);
      end
      foreach (probe[i]) begin
         rq_addr = 11'(probe[i]);
         #1;
         tests++;
         if (gain !== 11'd5) begin
            fails++;
            $display("FAIL idle_gain addr=%0d got=%0d exp=5", probe[i], gain);
         end
      end
      fill_shadow(11'd9, 1'b0);
      $display("[TB] test_idle_commit done");
   endtask

   task automatic test_arm_valid;
      host_arm = 1'b1;
      tick();
      host_arm = 1'b0;
      tests++;
      if (rq_arm !== 1'b1 || arm_err !== 1'b0) begin
         fails++;
         $display("FAIL arm_valid got rq_arm=%b arm_err=%b exp 1/0", rq_arm, arm_err);
      end
      tick();
      tests++;
      if (rq_arm !== 1'b0) begin
         fails++;
         $display("FAIL arm_pulse_width got rq_arm=%b exp 0", rq_arm);
      end
      $display("[TB] test_arm_valid done");
   endtask

   task automatic test_frame_swap;
      rq_addr = 11'd0;
      rq_sync = 1'b1;
      tick();
      rq_sync = 1'b0;
      tests++;
      if (running !== 1'b1) begin
         fails++;
         $display("FAIL running_set got=%b exp 1", running);
      end
      run_frame(0, 100, 200, 11'd5, N);
      tests++;
      if (busy !== 1'b1 || active_bank !== 1'b0) begin
         fails++;
         $display("FAIL frame_swap_edge got busy=%b bank=%b exp 1/0", busy, active_bank);
      end
      run_frame(0, -1, -1, 11'd9, N);
      tests++;
      if (busy !== 1'b0 || wr_drop !== 1'b1) begin
         fails++;
         $display("FAIL after_swap got busy=%b wr_drop=%b exp 0/1", busy, wr_drop);
      end
      $display("[TB] test_frame_swap done");
   endtask

   task automatic test_wr_drop_clear;
      run_frame(0, 50, -1, 11'd9, N);
      tests++;
      if (wr_drop !== 1'b0 || active_bank !== 1'b1) begin
         fails++;
         $display("FAIL wr_drop_clear got wr_drop=%b bank=%b exp 0/1", wr_drop, active_bank);
      end
      $display("[TB] test_wr_drop_clear done");
   endtask

   task automatic test_ovf_stats;
      run_frame(1, -1, -1, 11'd5, N);
      run_frame(2, -1, -1, 11'd5, N);
      run_frame(0, -1, -1, 11'd5, 1);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL sb_drain got=%0d pending exp 0", sb.size());
      end
      $display("[TB] test_ovf_stats done");
   endtask

   task automatic test_async_reset;
      host_commit = 1'b1;
      rq_addr     = 11'd300;
      tick();
      host_commit = 1'b0;
      tick();
      tests++;
      if (busy !== 1'b1 || active_bank !== 1'b1) begin
         fails++;
         $display("FAIL pending_before_rst got busy=%b bank=%b exp 1/1", busy, active_bank);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      tests++;
      if ({busy, active_bank, table_valid, running} !== 4'b0 || frame_cnt !== 32'd0 || ovf_last !== 12'd0) begin
         fails++;
         $display("FAIL async_rst got flags=%b frame_cnt=%0d ovf_last=%0d exp 0",
                  {busy, active_bank, table_valid, running}, frame_cnt, ovf_last);
      end
      tick();
      rst        = 1'b0;
      sb.delete();
      exp_frames = 0;
      ovf_pend   = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rq_addr = 11'(N - 1 - k);
         tick();
      end
      tests++;
      if (busy !== 1'b0 || active_bank !== 1'b0 || table_valid !== 1'b0) begin
         fails++;
         $display("FAIL no_swap_after_rst got busy=%b bank=%b valid=%b exp 0/0/0", busy, active_bank, table_valid);
      end
      $display("[TB] test_async_reset done");
   endtask

   task automatic test_ce_hold;
      ce          = 1'b0;
      host_commit = 1'b1;
      tick();
      host_commit = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      tests++;
      if (busy !== 1'b1 || active_bank !== 1'b0) begin
         fails++;
         $display("FAIL ce_hold got busy=%b bank=%b exp 1/0", busy, active_bank);
      end
      ce = 1'b1;
      tick();
      tests++;
      if (active_bank !== 1'b1 || table_valid !== 1'b1) begin
         fails++;
         $display("FAIL ce_resume got bank=%b valid=%b exp 1/1", active_bank, table_valid);
      end
      rq_addr = 11'd9;
      #1;
      tests++;
      if (gain !== 11'd5) begin
         fails++;
         $display("FAIL ram_kept got=%0d exp=5", gain);
      end
      $display("[TB] test_ce_hold done");
   endtask

   initial begin
      test_reset();
      test_arm_before_table();
      test_idle_commit();
      test_arm_valid();
      test_frame_swap();
      test_wr_drop_clear();
      test_ovf_stats();
      test_async_reset();
      test_ce_hold();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
